// File: rtl/fp_pkg.sv
// Shared constants and types for the binary32 normalize/round stage.
package fp_pkg;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    localparam logic [31:0] FP_QZERO = 32'h0000_0000;
    localparam logic [31:0] FP_INF   = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        of;
        logic        uf;
        logic        nx;
    } round_res_t;

    function automatic logic [31:0] fp_with_sign(input logic s, input logic [31:0] mag);
        return {s, mag[30:0]};
    endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Operand-in / result-out handshake bundle of the normalize/round stage.
interface fp_norm_round_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_of;
    logic        out_uf;
    logic        out_nx;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_of, out_uf, out_nx
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_of, out_uf, out_nx
    );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and binary32 packing of a normalized operand.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [26:0]       mant,
    input  logic              zero_flag,
    input  logic              uf_flag,
    output logic [31:0]       result,
    output logic              of,
    output logic              uf,
    output logic              nx
);

    localparam logic signed [10:0] EXP_MAX_S = 11'(FP_EXP_MAX);

    logic              round_up;
    logic [24:0]       sum;
    logic              carry;
    logic [22:0]       frac;
    logic signed [10:0] exp_r;

    always_comb begin
        round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
        sum      = {1'b0, mant[26:3]} + {24'd0, round_up};
        carry    = sum[24];
        // On carry-out the significand is renormalized by one bit (fraction becomes zero)
        frac     = carry ? sum[23:1] : sum[22:0];
        exp_r    = {exp[9], exp} + {10'd0, carry};
    end

    always_comb begin
        result = FP_QZERO;
        of     = 1'b0;
        uf     = 1'b0;
        nx     = 1'b0;
        if (uf_flag) begin
            result = fp_with_sign(sign, FP_QZERO);
            uf     = 1'b1;
            nx     = 1'b1;
        end else if (zero_flag) begin
            result = fp_with_sign(sign, FP_QZERO);
        end else if (exp_r >= EXP_MAX_S) begin
            result = fp_with_sign(sign, FP_INF);
            of     = 1'b1;
            nx     = 1'b1;
        end else begin
            result = {sign, exp_r[7:0], frac};
            nx     = mant[2] | mant[1] | mant[0];
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Iterative one-bit-per-cycle normalizer feeding an RNE rounder; emits packed binary32.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    fp_norm_round_if.slave bus
);

    norm_state_t        state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [27:0]        mant_q, mant_d;
    logic               zero_q, zero_d;
    logic               uf_q, uf_d;
    round_res_t         res_q, res_d;
    round_res_t         rnd_res;

    logic               accept;
    logic               mant_zero;
    logic               exp_le_zero;

    assign accept      = (state_q == IDLE) && bus.in_valid && !flush;
    assign mant_zero   = (mant_q == 28'd0);
    assign exp_le_zero = (exp_q <= 10'sd0);

    fp_round_rne u_round (
        .sign      (sign_q),
        .exp       (exp_q),
        .mant      (mant_q[26:0]),
        .zero_flag (zero_q),
        .uf_flag   (uf_q),
        .result    (rnd_res.result),
        .of        (rnd_res.of),
        .uf        (rnd_res.uf),
        .nx        (rnd_res.nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (bus.in_valid) state_d = NORM;
                NORM:  if (mant_zero || exp_le_zero || (mant_q[27:26] == 2'b01)) state_d = ROUND;
                ROUND: state_d = DONE;
                DONE:  if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.out_result = res_q.result;
        bus.out_of     = res_q.of;
        bus.out_uf     = res_q.uf;
        bus.out_nx     = res_q.nx;
    end

    // Operand datapath: one normalization action per NORM cycle, zero/underflow checked first
    always_comb begin
        sign_d = sign_q;
        exp_d  = exp_q;
        mant_d = mant_q;
        zero_d = zero_q;
        uf_d   = uf_q;
        res_d  = res_q;
        if (accept) begin
            sign_d = bus.in_sign;
            exp_d  = $signed(bus.in_exp);
            mant_d = bus.in_mant;
            zero_d = 1'b0;
            uf_d   = 1'b0;
        end else if (!flush && state_q == NORM) begin
            if (mant_zero) begin
                zero_d = 1'b1;
            end else if (exp_le_zero) begin
                uf_d = 1'b1;
            end else if (mant_q[27]) begin
                mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                exp_d  = exp_q + 10'sd1;
            end else if (!mant_q[26]) begin
                mant_d = {mant_q[26:0], 1'b0};
                exp_d  = exp_q - 10'sd1;
            end
        end else if (!flush && state_q == ROUND) begin
            res_d = rnd_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= 10'sd0;
            mant_q <= 28'd0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
            res_q  <= '0;
        end else begin
            sign_q <= sign_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            zero_q <= zero_d;
            uf_q   <= uf_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed vector table plus handshake/flush/reset sequences for fp_norm_round.
module tb_fp_norm_round;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    fp_norm_round_if bus ();

    fp_norm_round dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [27:0] mant;
        logic [31:0] result;
        logic [2:0]  flags;   // {of, uf, nx}
        int          k;       // expected NORM shift steps
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called #1 after an edge while in IDLE; returns #1 after the accept edge.
    task automatic start_op(input vec_t v);
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_mant  = v.mant;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency = edges from the accept edge to the first edge at which out_valid is sampled high.
    task automatic wait_valid(output int lat, output bit found);
        int cyc;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid) found = 1'b1;
        end
        lat = cyc + 1;
    endtask

    initial begin
        int lat;
        bit found;
        int seen;
        int accepts;
        string nm;

        vecs[0]  = '{1'b0, 10'd127,  28'h4000000, 32'h3F800000, 3'b000, 0};
        vecs[1]  = '{1'b0, 10'd127,  28'h8000000, 32'h40000000, 3'b000, 1};
        vecs[2]  = '{1'b0, 10'd150,  28'h0000008, 32'h3F800000, 3'b000, 23};
        vecs[3]  = '{1'b0, 10'd127,  28'h7FFFFFC, 32'h40000000, 3'b001, 0};
        vecs[4]  = '{1'b0, 10'd254,  28'h7FFFFFC, 32'h7F800000, 3'b101, 0};
        vecs[5]  = '{1'b1, 10'd1,    28'h2000000, 32'h80000000, 3'b011, 1};
        vecs[6]  = '{1'b0, 10'd127,  28'h0000000, 32'h00000000, 3'b000, 0};
        vecs[7]  = '{1'b1, 10'd127,  28'h0000000, 32'h80000000, 3'b000, 0};
        vecs[8]  = '{1'b0, 10'd127,  28'h4000004, 32'h3F800000, 3'b001, 0};
        vecs[9]  = '{1'b0, 10'd127,  28'h400000C, 32'h3F800002, 3'b001, 0};
        vecs[10] = '{1'b1, 10'd127,  28'h8000001, 32'hC0000000, 3'b001, 1};
        vecs[11] = '{1'b0, 10'h3FB,  28'h4000000, 32'h00000000, 3'b011, 0};
        vecs[12] = '{1'b0, 10'd255,  28'h4000000, 32'h7F800000, 3'b101, 0};
        vecs[13] = '{1'b0, 10'd254,  28'h4000000, 32'h7F000000, 3'b000, 0};
        vecs[14] = '{1'b0, 10'd130,  28'h0000001, 32'h34000000, 3'b000, 26};
        vecs[15] = '{1'b0, 10'd127,  28'h4000002, 32'h3F800000, 3'b001, 0};

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_result",    bus.out_result,     32'h0);
        check("rst_flags",     32'({bus.out_of, bus.out_uf, bus.out_nx}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i]);
            wait_valid(lat, found);
            nm = $sformatf("vec%0d_timeout", i);
            check(nm, 32'(found), 32'd1);
            nm = $sformatf("vec%0d_latency", i);
            check(nm, 32'(lat), 32'(3 + vecs[i].k));
            nm = $sformatf("vec%0d_result", i);
            check(nm, bus.out_result, vecs[i].result);
            nm = $sformatf("vec%0d_flags", i);
            check(nm, 32'({bus.out_of, bus.out_uf, bus.out_nx}), 32'(vecs[i].flags));
            $display("vec %0d: exp=%h mant=%h -> result=%h of/uf/nx=%b latency=%0d",
                     i, vecs[i].exp, vecs[i].mant, bus.out_result,
                     {bus.out_of, bus.out_uf, bus.out_nx}, lat);
            @(posedge clk);
            #1;
            nm = $sformatf("vec%0d_post_idle", i);
            check(nm, 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end

        // Backpressure: result must hold in DONE while out_ready is low
        bus.out_ready = 1'b0;
        start_op(vecs[9]);
        wait_valid(lat, found);
        check("bp_reach_done", 32'(found), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid",  32'({bus.out_valid, bus.in_ready}), 32'b10);
            check("bp_hold_result", bus.out_result, 32'h3F800002);
        end
        $display("backpressure: held result=%h for 5 cycles", bus.out_result);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);

        // Flush in the middle of a long normalization
        start_op(vecs[14]);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        $display("flush mid-NORM: out_valid cycles afterwards=%0d", seen);

        // Flush wins over an accept in the same cycle
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'd127;
        bus.in_mant  = 28'h4000000;
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_beats_accept", 32'(bus.in_ready), 32'd1);
        $display("flush+accept: in_ready=%b", bus.in_ready);

        // Asynchronous reset mid-NORM clears outputs before the next edge
        start_op(vecs[14]);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_result",   bus.out_result, 32'h0);
        check("arst_handshk",  32'({bus.out_valid, bus.in_ready}), 32'b01);
        $display("async reset mid-NORM: result=%h in_ready=%b", bus.out_result, bus.in_ready);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back: one accept every latency+1 = 4 cycles for normalized operands
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'd127;
        bus.in_mant  = 28'h4000000;
        bus.in_valid = 1'b1;
        accepts = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.in_ready) accepts++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd5);
        $display("back-to-back: %0d accepts in 20 cycles", accepts);
        @(posedge clk);
        #1;
        check("b2b_final_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Iterative normalize-and-round stage of the FP datapath. Takes the unnormalized sign/exponent/mantissa produced by the FP add/mul execute stage, normalizes by one bit per cycle, applies round-to-nearest-even, and emits a packed IEEE-754 binary32 word. That word is what the writeback mux selects as its normalized-result source. Denormals are not supported; tiny results flush to signed zero.

## Interface
- Parameters: none; widths are fixed for binary32.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous abort; returns the block to IDLE
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  block can accept an operand; high only in IDLE
- `in_sign`  in  1  sign
- `in_exp`  in  10  two's-complement biased exponent
- `in_mant`  in  28  mantissa:
  - bit 27: carry
  - bit 26: hidden bit
  - bits 25:3: fraction
  - bit 2: guard (G); bit 1: round (R); bit 0: sticky (S)
  - value = (-1)^sign × (mant / 2^26) × 2^(exp−127)
- `out_valid`  out  1  result valid; held until taken
- `out_ready`  in  1  consumer accepts
- `out_result`  out  32  packed binary32 result
- `out_of`  out  1  overflow
- `out_uf`  out  1  underflow (flushed to zero)
- `out_nx`  out  1  inexact

## Operation
- **FSM states:** IDLE, NORM, ROUND, DONE.
- **Reset:** state = IDLE. `out_valid`, `out_result`, `out_of`, `out_uf`, `out_nx` = 0. `in_ready` = 1.
- **IDLE:** on `in_valid && in_ready`, latch sign/exp/mant, then go to NORM.
- **NORM:** exactly one action per cycle, in this priority order:
  - mant == 0 → zero flag set, go to ROUND.
  - exp ≤ 0 → underflow flag set, go to ROUND.
  - mant[27] = 1 → mant >>= 1 with the shifted-out bit ORed into S; exp += 1. Stay in NORM.
  - mant[27:26] = 01 → go to ROUND.
  - otherwise → mant <<= 1 (zero fill); exp −= 1. Stay in NORM.
- **ROUND:** one cycle, combinational RNE.
  - Round-up condition: `G & (R | S | mant[3])`.
  - Rounding applies to the 24-bit significand mant[26:3].
  - If the significand carries out to 2^24: significand = 1.0, exp += 1.
  - Result selection (signed zero keeps in_sign):
    - underflow flag set → signed zero, `uf` = 1, `nx` = 1.
    - zero flag set → signed zero, all flags 0.
    - exp ≥ 255 after rounding → signed infinity (`{s,8'hFF,23'b0}`), `of` = 1, `nx` = 1.
    - otherwise → `{s, exp[7:0], frac[22:0]}`, `nx` = G|R|S.
  - Go to DONE.
- **DONE:** `out_valid` = 1 and all outputs held stable. On `out_ready`, go to IDLE; `out_valid` drops the next cycle.
- **Flush:** `flush` in any state → IDLE next cycle, `out_valid` = 0, in-flight operand discarded. Flush has priority over an accept in the same cycle.
- **Exponent arithmetic:** 10-bit signed. Overflow/underflow compares are signed.

## Timing
- Operand accepted at edge 0 → `out_valid` high after edge 3 + k, where k = number of NORM shift steps.
  - Already-normalized operand: k = 0, latency 3.
  - Carry operand: k = 1, latency 4.
  - Maximum: 26 left shifts, latency 29.
- No overlap: `in_ready` stays low from the accept edge until DONE is left.
  - Back-to-back operands: one accept per (latency + 1) cycles when `out_ready` = 1.
- Async `rst` mid-operation: immediately forces the reset values; the operand is lost.

## Structure
- Package `fp_pkg` contains:
  - `FP_BIAS` = 127, `FP_EXP_MAX` = 255
  - `FP_QZERO`, `FP_INF` constants
  - `norm_state_t` enum (IDLE/NORM/ROUND/DONE)
- Sub-module `fp_round_rne` (combinational):
  - inputs: sign, exp, mant[26:0], zero/underflow flags
  - outputs: result, of/uf/nx
- The top level holds the FSM, the operand registers, and the shifter.

## Test plan
- **Normalized input:** s=0, exp=127, mant=0x4000000 → `out_result` = 0x3F800000, flags 0, `out_valid` 3 cycles after accept.
- **Carry:** exp=127, mant=0x8000000 → 0x40000000 at latency 4. Long shift: exp=150, mant=0x0000008 → 0x3F800000 at latency 26.
- **Rounding carry:** exp=127, mant=0x7FFFFFC → 0x40000000, `nx` = 1. Same mantissa with exp=254 → 0x7F800000, `of` = 1, `nx` = 1.
- **Underflow and zero:**
  - s=1, exp=1, mant=0x2000000 → 0x80000000, `uf` = 1, `nx` = 1.
  - mant=0 → 0x00000000 with all flags 0.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles in DONE → `out_valid` and `out_result` stable, `in_ready` = 0. Release → one handshake, IDLE.
- **Abort:** assert `flush` in NORM → `out_valid` never rises, `in_ready` = 1 next cycle. Async `rst` mid-NORM → all outputs 0 immediately.
